mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage sequencer sitting directly upstream of DATA_MEM. Accepts one memory op per handshake
//  (LDD/STD/PUSH/POP/CALL/RET/INT/RTI), owns the stack pointer, and generates DATA_MEM controls.
//  Returns load/pop data to writeback. Splits INT/RTI into two DATA_MEM accesses.
// PARAMETERS
//  ADDR_W    32           address / SP width
//  SP_RESET  32'h000FFFFF SP after reset; top of stack, empty-stack boundary
// PORTS
//  clk         in   1   clock; all state on posedge
//  rst         in   1   synchronous, active-high reset
//  i_valid     in   1   op request; hold with stable inputs until accepted
//  o_ready     out  1   1 only in IDLE; accept = i_valid & o_ready at posedge
//  i_op        in   3   0 LDD,1 STD,2 PUSH,3 POP,4 CALL,5 RET,6 INT,7 RTI
//  i_en32      in   1   LDD/STD width: 1=32-bit, 0=16-bit (ignored for other ops)
//  i_ea        in   32  effective address for LDD/STD
//  i_wdata     in   32  store/push data; PC for CALL/INT
//  i_flags     in   16  flags pushed by INT
//  o_mem_read  out  1   to DATA_MEM i_memRead
//  o_mem_write out  1   to DATA_MEM i_memWrite
//  o_en32      out  1   to DATA_MEM i_en32
//  o_address   out  32  to DATA_MEM i_address
//  o_mem_wdata out  32  to DATA_MEM i_data_in
//  i_mem_rdata in   32  from DATA_MEM o_data_out (valid cycle after read issue)
//  o_valid     out  1   one-cycle completion pulse
//  o_rdata     out  32  LDD/POP/RET data; PC for RTI; 0 otherwise; held until next o_valid
//  o_flags     out  16  flags popped by RTI; held otherwise
//  o_exc       out  1   with o_valid: op aborted, no access performed
//  o_sp        out  32  current SP
// BEHAVIOUR
//  Reset: state IDLE, o_sp=SP_RESET, o_ready=1, all other outputs 0. rst wins over all events; an op in
//   flight is dropped (accesses already issued stand, SP restored to SP_RESET).
//  States: IDLE -> ACC1 -> WAIT1 -> [ACC2 -> WAIT2 ->] RESP -> IDLE. INT/RTI use ACC2/WAIT2.
//   Error ops go IDLE -> RESP.
//  Accept captures op, en32, ea, wdata, flags; inputs ignored when o_ready=0.
//  DATA_MEM controls registered, nonzero only in ACCx; o_mem_read/o_mem_write=0 elsewhere.
//   Read data sampled at the end of WAITx.
//  Latency: o_valid in cycle 3 after accept edge (1 access), 5 (2 accesses), 1 (exc).
//  32-bit access at A touches words A-1 (high) and A (low), same as DATA_MEM. Stack grows down;
//   SP points to next free word.
//  Per access (addr, width, SP update at end of that ACC):
//   LDD/STD: ea, i_en32, SP unchanged.
//   PUSH: SP, 16, SP-=1.
//   POP: SP+1, 16, SP+=1.
//   CALL: SP, 32, SP-=2.
//   RET: SP+2, 32, SP+=2.
//   INT: ACC1 PC at SP (32, SP-=2); ACC2 flags at new SP (16, SP-=1).
//   RTI: ACC1 flags at SP+1 (16, SP+=1); ACC2 PC at new SP+2 (32, SP+=2).
//  16-bit read result zero-extended (upper 16 = 0). 16-bit write uses wdata[15:0].
//  Address math is modulo 2^ADDR_W.
//  o_exc=1 (no access, SP unchanged, o_rdata=0) when:
//   POP with SP+1 > SP_RESET; RET with SP+2 > SP_RESET; RTI with SP+3 > SP_RESET;
//   LDD/STD with en32=1 and ea==0.
//  Comparisons are unsigned. Push below address 0 wraps silently.
//  o_valid and o_exc are high for exactly one cycle (RESP).
// TESTING
//  1. Reset, STD en32 ea=0x10 wdata=0xDEADBEEF, then LDD en32 ea=0x10
//     -> write pulse addr 0x10; o_rdata=0xDEADBEEF 3 cycles after accept.
//  2. PUSH 0x1234, PUSH 0xABCD, POP, POP -> o_rdata 0xABCD then 0x1234;
//     o_sp 0xFFFFE, 0xFFFFD, 0xFFFFE, 0xFFFFF.
//  3. INT PC=0x00400020 flags=0x0007, then RTI -> 2 writes at 0xFFFFF, 0xFFFFD; o_sp=0xFFFFC;
//     RTI o_flags=0x0007, o_rdata=0x00400020, o_sp=0xFFFFF; 5-cycle latency each.
//  4. POP at SP=SP_RESET; LDD en32 ea=0 -> o_valid&o_exc 1 cycle after accept; no mem strobe;
//     SP unchanged.
//  5. i_valid held during busy -> exactly one accept per op; o_ready low ACC1..RESP.
//  6. rst asserted in WAIT1 of CALL -> next cycle IDLE, o_sp=0xFFFFF, o_valid never pulses.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer in front of DATA_MEM: owns the stack pointer, issues registered
// DATA_MEM controls and splits INT/RTI into two accesses.
module mem_stage_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(32'h000F_FFFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic              i_en32,
    input  logic [ADDR_W-1:0] i_ea,
    input  logic [31:0]       i_wdata,
    input  logic [15:0]       i_flags,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_en32,
    output logic [ADDR_W-1:0] o_address,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_valid,
    output logic [31:0]       o_rdata,
    output logic [15:0]       o_flags,
    output logic              o_exc,
    output logic [ADDR_W-1:0] o_sp
);
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] OP_LDD  = 3'd0;
    localparam logic [2:0] OP_STD  = 3'd1;
    localparam logic [2:0] OP_PUSH = 3'd2;
    localparam logic [2:0] OP_POP  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_INT  = 3'd6;
    localparam logic [2:0] OP_RTI  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_ACC1, S_WAIT1, S_ACC2, S_WAIT2, S_RESP} state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [HALF_W-1:0]   r_flags_in;
    logic [HALF_W-1:0]   r_flags_tmp;
    logic                r_last_rd;
    logic                r_last_wide;

    logic                w_second;
    logic [2:0]          w_op;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic                w_acc_en32;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [31:0]         w_acc_wdata;
    logic                w_exc;
    logic                w_two;
    logic [ADDR_W-1:0]   w_sp_next;
    logic [31:0]         w_rd_result;

    // Next access: first access comes straight from the request, second from captured op and updated SP
    always_comb begin
        w_acc_rd    = 1'b0;
        w_acc_wr    = 1'b0;
        w_acc_en32  = 1'b0;
        w_acc_addr  = '0;
        w_acc_wdata = '0;
        w_second    = (r_state == S_WAIT1);
        w_op        = w_second ? r_op : i_op;
        case (w_op)
            OP_LDD: begin
                w_acc_rd   = 1'b1;
                w_acc_en32 = i_en32;
                w_acc_addr = i_ea;
            end
            OP_STD: begin
                w_acc_wr    = 1'b1;
                w_acc_en32  = i_en32;
                w_acc_addr  = i_ea;
                w_acc_wdata = i_en32 ? i_wdata : {{HALF_W{1'b0}}, i_wdata[HALF_W-1:0]};
            end
            OP_PUSH: begin
                w_acc_wr    = 1'b1;
                w_acc_addr  = o_sp;
                w_acc_wdata = {{HALF_W{1'b0}}, i_wdata[HALF_W-1:0]};
            end
            OP_POP: begin
                w_acc_rd   = 1'b1;
                w_acc_addr = o_sp + ADDR_W'(1);
            end
            OP_CALL: begin
                w_acc_wr    = 1'b1;
                w_acc_en32  = 1'b1;
                w_acc_addr  = o_sp;
                w_acc_wdata = i_wdata;
            end
            OP_RET: begin
                w_acc_rd   = 1'b1;
                w_acc_en32 = 1'b1;
                w_acc_addr = o_sp + ADDR_W'(2);
            end
            OP_INT: begin
                w_acc_wr    = 1'b1;
                w_acc_addr  = o_sp;
                w_acc_en32  = !w_second;
                w_acc_wdata = w_second ? {{HALF_W{1'b0}}, r_flags_in} : i_wdata;
            end
            default: begin
                w_acc_rd   = 1'b1;
                w_acc_en32 = w_second;
                w_acc_addr = w_second ? o_sp + ADDR_W'(2) : o_sp + ADDR_W'(1);
            end
        endcase
    end

    // Abort checks on the incoming request; empty-stack boundary is SP_RESET
    always_comb begin
        w_exc = 1'b0;
        case (i_op)
            OP_LDD, OP_STD: w_exc = i_en32 && (i_ea == '0);
            OP_POP:         w_exc = (o_sp + ADDR_W'(1)) > SP_RESET;
            OP_RET:         w_exc = (o_sp + ADDR_W'(2)) > SP_RESET;
            OP_RTI:         w_exc = (o_sp + ADDR_W'(3)) > SP_RESET;
            default:        w_exc = 1'b0;
        endcase
    end

    always_comb begin
        w_two     = (r_op == OP_INT) || (r_op == OP_RTI);
        w_sp_next = o_sp;
        if (r_state == S_ACC1) begin
            case (r_op)
                OP_PUSH: w_sp_next = o_sp - ADDR_W'(1);
                OP_POP:  w_sp_next = o_sp + ADDR_W'(1);
                OP_CALL: w_sp_next = o_sp - ADDR_W'(2);
                OP_RET:  w_sp_next = o_sp + ADDR_W'(2);
                OP_INT:  w_sp_next = o_sp - ADDR_W'(2);
                OP_RTI:  w_sp_next = o_sp + ADDR_W'(1);
                default: w_sp_next = o_sp;
            endcase
        end else if (r_state == S_ACC2) begin
            w_sp_next = (r_op == OP_INT) ? o_sp - ADDR_W'(1) : o_sp + ADDR_W'(2);
        end
        if (!r_last_rd)
            w_rd_result = '0;
        else if (r_last_wide)
            w_rd_result = i_mem_rdata;
        else
            w_rd_result = {{HALF_W{1'b0}}, i_mem_rdata[HALF_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LDD;
            r_flags_in  <= '0;
            r_flags_tmp <= '0;
            r_last_rd   <= 1'b0;
            r_last_wide <= 1'b0;
            o_ready     <= 1'b1;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_en32      <= 1'b0;
            o_address   <= '0;
            o_mem_wdata <= '0;
            o_valid     <= 1'b0;
            o_rdata     <= '0;
            o_flags     <= '0;
            o_exc       <= 1'b0;
            o_sp        <= SP_RESET;
        end else begin
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_en32      <= 1'b0;
            o_address   <= '0;
            o_mem_wdata <= '0;
            o_valid     <= 1'b0;
            o_exc       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_op       <= i_op;
                        r_flags_in <= i_flags;
                        o_ready    <= 1'b0;
                        if (w_exc) begin
                            r_state <= S_RESP;
                            o_valid <= 1'b1;
                            o_exc   <= 1'b1;
                            o_rdata <= '0;
                        end else begin
                            r_state     <= S_ACC1;
                            o_mem_read  <= w_acc_rd;
                            o_mem_write <= w_acc_wr;
                            o_en32      <= w_acc_en32;
                            o_address   <= w_acc_addr;
                            o_mem_wdata <= w_acc_wdata;
                            r_last_rd   <= w_acc_rd;
                            r_last_wide <= w_acc_en32;
                        end
                    end
                end
                S_ACC1: begin
                    o_sp    <= w_sp_next;
                    r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (w_two) begin
                        r_state     <= S_ACC2;
                        r_flags_tmp <= i_mem_rdata[HALF_W-1:0];
                        o_mem_read  <= w_acc_rd;
                        o_mem_write <= w_acc_wr;
                        o_en32      <= w_acc_en32;
                        o_address   <= w_acc_addr;
                        o_mem_wdata <= w_acc_wdata;
                        r_last_rd   <= w_acc_rd;
                        r_last_wide <= w_acc_en32;
                    end else begin
                        r_state <= S_RESP;
                        o_valid <= 1'b1;
                        o_rdata <= w_rd_result;
                    end
                end
                S_ACC2: begin
                    o_sp    <= w_sp_next;
                    r_state <= S_WAIT2;
                end
                S_WAIT2: begin
                    r_state <= S_RESP;
                    o_valid <= 1'b1;
                    o_rdata <= w_rd_result;
                    if (r_op == OP_RTI)
                        o_flags <= r_flags_tmp;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: DATA_MEM behavioural model plus an op-level reference model of
// stack/memory semantics; directed scenarios followed by randomized ops.
module tb_mem_stage_ctrl;
    localparam logic [31:0] SPR = 32'h000F_FFFF;
    localparam logic [2:0] LDD = 3'd0, STD = 3'd1, PUSH = 3'd2, POP = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, INT = 3'd6, RTI = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_en32;
    logic [2:0]  i_op;
    logic [31:0] i_ea, i_wdata;
    logic [15:0] i_flags;
    logic        o_mem_read, o_mem_write, o_en32;
    logic [31:0] o_address, o_mem_wdata, mem_rdata;
    logic        o_valid, o_exc;
    logic [31:0] o_rdata, o_sp;
    logic [15:0] o_flags;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .i_en32(i_en32), .i_ea(i_ea), .i_wdata(i_wdata), .i_flags(i_flags),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_en32(o_en32),
        .o_address(o_address), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata),
        .o_valid(o_valid), .o_rdata(o_rdata), .o_flags(o_flags), .o_exc(o_exc), .o_sp(o_sp)
    );

    int n_checks = 0;
    int n_err    = 0;

    // DATA_MEM model (16-bit words, 32-bit access at A = {A-1, A}) and strobe monitor
    logic [15:0] dmem [logic [31:0]];
    logic [15:0] rmem [logic [31:0]];
    logic [31:0] wr_addr_q [$];
    int n_wr, n_rd, n_acc;

    function automatic logic [15:0] dget(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 16'h0;
    endfunction
    function automatic logic [15:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 16'h0;
    endfunction

    always @(posedge clk) begin
        if (i_valid && o_ready && !rst) n_acc++;
        if (o_mem_write) begin
            n_wr++;
            wr_addr_q.push_back(o_address);
            if (o_en32) dmem[o_address - 32'd1] = o_mem_wdata[31:16];
            dmem[o_address] = o_mem_wdata[15:0];
        end
        if (o_mem_read) begin
            n_rd++;
            mem_rdata <= o_en32 ? {dget(o_address - 32'd1), dget(o_address)}
                                : {16'hA5A5, dget(o_address)};
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Reference model state, updated one whole op at a time
    logic [31:0] ref_sp;
    logic [31:0] ref_rdata;
    logic [15:0] ref_flags;
    bit          exp_exc;
    int          exp_lat, exp_nwr, exp_nrd;

    task automatic ref_apply(input logic [2:0] op, input logic en32, input logic [31:0] ea,
                             input logic [31:0] wd, input logic [15:0] fl);
        exp_exc = 1'b0; exp_nwr = 0; exp_nrd = 0; exp_lat = 3; ref_rdata = 32'h0;
        case (op)
            LDD: if (en32 && ea == 32'h0) exp_exc = 1'b1;
                 else begin
                     exp_nrd = 1;
                     ref_rdata = en32 ? {rget(ea - 32'd1), rget(ea)} : {16'h0, rget(ea)};
                 end
            STD: if (en32 && ea == 32'h0) exp_exc = 1'b1;
                 else begin
                     exp_nwr = 1;
                     if (en32) rmem[ea - 32'd1] = wd[31:16];
                     rmem[ea] = wd[15:0];
                 end
            PUSH: begin exp_nwr = 1; rmem[ref_sp] = wd[15:0]; ref_sp = ref_sp - 32'd1; end
            POP: if (ref_sp + 32'd1 > SPR) exp_exc = 1'b1;
                 else begin exp_nrd = 1; ref_sp = ref_sp + 32'd1; ref_rdata = {16'h0, rget(ref_sp)}; end
            CALL: begin
                exp_nwr = 1; rmem[ref_sp - 32'd1] = wd[31:16]; rmem[ref_sp] = wd[15:0];
                ref_sp = ref_sp - 32'd2;
            end
            RET: if (ref_sp + 32'd2 > SPR) exp_exc = 1'b1;
                 else begin
                     exp_nrd = 1; ref_sp = ref_sp + 32'd2;
                     ref_rdata = {rget(ref_sp - 32'd1), rget(ref_sp)};
                 end
            INT: begin
                exp_nwr = 2; exp_lat = 5;
                rmem[ref_sp - 32'd1] = wd[31:16]; rmem[ref_sp] = wd[15:0];
                ref_sp = ref_sp - 32'd2;
                rmem[ref_sp] = fl; ref_sp = ref_sp - 32'd1;
            end
            default: if (ref_sp + 32'd3 > SPR) exp_exc = 1'b1;
                 else begin
                     exp_nrd = 2; exp_lat = 5;
                     ref_sp = ref_sp + 32'd1; ref_flags = rget(ref_sp);
                     ref_sp = ref_sp + 32'd2; ref_rdata = {rget(ref_sp - 32'd1), rget(ref_sp)};
                 end
        endcase
        if (exp_exc) exp_lat = 1;
    endtask

    // Observations of the last op
    int          obs_lat;
    bit          obs_timeout, obs_ready_busy, obs_valid_after, obs_ready_after, obs_exc;
    logic [31:0] obs_rdata, obs_sp;
    logic [15:0] obs_flags;

    task automatic do_op(input logic [2:0] op, input logic en32, input logic [31:0] ea,
                         input logic [31:0] wd, input logic [15:0] fl, input bit hold);
        n_wr = 0; n_rd = 0; n_acc = 0; wr_addr_q.delete();
        obs_timeout = 1'b0; obs_ready_busy = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_en32 = en32; i_ea = ea; i_wdata = wd; i_flags = fl;
        @(posedge clk); #1;
        obs_lat = 1;
        if (!hold) begin
            i_valid = 1'b0; i_op = 3'($urandom); i_en32 = 1'($urandom);
            i_ea = $urandom; i_wdata = $urandom; i_flags = 16'($urandom);
        end
        while (!o_valid && obs_lat < 12) begin
            obs_ready_busy |= o_ready;
            @(posedge clk); #1;
            obs_lat++;
        end
        obs_ready_busy |= o_ready;
        if (!o_valid) obs_timeout = 1'b1;
        obs_exc = o_exc; obs_rdata = o_rdata; obs_flags = o_flags; obs_sp = o_sp;
        i_valid = 1'b0;
        @(posedge clk); #1;
        obs_valid_after = o_valid; obs_ready_after = o_ready;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk); rst = 1'b0;
        ref_sp = SPR; ref_rdata = 32'h0; ref_flags = 16'h0;
        n_checks++;
        if ({o_ready, o_sp} !== {1'b1, SPR}) begin
            n_err++; $display("FAIL reset_ready_sp: got %b/%h want 1/%h", o_ready, o_sp, SPR);
        end
        n_checks++;
        if ({o_valid, o_exc, o_mem_read, o_mem_write, o_en32, o_address, o_mem_wdata, o_rdata, o_flags} !== '0) begin
            n_err++; $display("FAIL reset_outputs: valid=%b exc=%b rd=%b wr=%b addr=%h rdata=%h flags=%h want all 0",
                              o_valid, o_exc, o_mem_read, o_mem_write, o_address, o_rdata, o_flags);
        end
    endtask

    task automatic test_ld_st();
        ref_apply(STD, 1'b1, 32'h10, 32'hDEAD_BEEF, 16'h0);
        do_op(STD, 1'b1, 32'h10, 32'hDEAD_BEEF, 16'h0, 1'b0);
        n_checks++;
        if (n_wr != 1 || wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h10 || obs_lat != 3) begin
            n_err++; $display("FAIL std_write: writes=%0d lat=%0d want 1 write @0x10 lat 3", n_wr, obs_lat);
        end
        ref_apply(LDD, 1'b1, 32'h10, 32'h0, 16'h0);
        do_op(LDD, 1'b1, 32'h10, 32'h0, 16'h0, 1'b0);
        n_checks++;
        if (obs_rdata !== 32'hDEAD_BEEF || obs_lat != 3 || obs_exc !== 1'b0) begin
            n_err++; $display("FAIL ldd_read: rdata=%h lat=%0d exc=%b want deadbeef 3 0", obs_rdata, obs_lat, obs_exc);
        end
    endtask

    task automatic test_stack();
        logic [31:0] want_d [4];
        logic [31:0] want_sp [4];
        logic [2:0]  ops [4];
        logic [31:0] wds [4];
        ops = '{PUSH, PUSH, POP, POP};
        wds = '{32'h1234, 32'hABCD, 32'h0, 32'h0};
        want_d = '{32'h0, 32'h0, 32'hABCD, 32'h1234};
        want_sp = '{32'hFFFFE, 32'hFFFFD, 32'hFFFFE, 32'hFFFFF};
        for (int i = 0; i < 4; i++) begin
            ref_apply(ops[i], 1'b0, 32'h0, wds[i], 16'h0);
            do_op(ops[i], 1'b0, 32'h0, wds[i], 16'h0, 1'b0);
            n_checks++;
            if (obs_rdata !== want_d[i] || obs_sp !== want_sp[i] || obs_lat != 3) begin
                n_err++; $display("FAIL stack_op%0d: rdata=%h sp=%h lat=%0d want %h %h 3",
                                  i, obs_rdata, obs_sp, obs_lat, want_d[i], want_sp[i]);
            end
        end
    endtask

    task automatic test_int_rti();
        ref_apply(INT, 1'b0, 32'h0, 32'h0040_0020, 16'h0007);
        do_op(INT, 1'b0, 32'h0, 32'h0040_0020, 16'h0007, 1'b0);
        n_checks++;
        if (wr_addr_q.size() != 2 || obs_sp !== 32'hFFFFC || obs_lat != 5) begin
            n_err++; $display("FAIL int_seq: writes=%0d sp=%h lat=%0d want 2 fffffc 5", wr_addr_q.size(), obs_sp, obs_lat);
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 32'hFFFFF || wr_addr_q[1] !== 32'hFFFFD) begin
                n_err++; $display("FAIL int_addr: got %h,%h want fffff,ffffd", wr_addr_q[0], wr_addr_q[1]);
            end
        end
        ref_apply(RTI, 1'b0, 32'h0, 32'h0, 16'h0);
        do_op(RTI, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
        n_checks++;
        if (obs_flags !== 16'h0007 || obs_rdata !== 32'h0040_0020 || obs_sp !== 32'hFFFFF || obs_lat != 5) begin
            n_err++; $display("FAIL rti_seq: flags=%h rdata=%h sp=%h lat=%0d want 0007 00400020 fffff 5",
                              obs_flags, obs_rdata, obs_sp, obs_lat);
        end
    endtask

    task automatic test_exc();
        logic [2:0]  ops [6];
        logic        en [6];
        logic [31:0] eas [6];
        bit          want_exc [6];
        // POP on empty, LDD32@0, PUSH, RET one word short, POP ok, LDD16@0 ok
        ops = '{POP, LDD, PUSH, RET, POP, LDD};
        en  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        eas = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        want_exc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            logic [31:0] sp_before;
            sp_before = o_sp;
            ref_apply(ops[i], en[i], eas[i], 32'h0000_5A5A, 16'h0);
            do_op(ops[i], en[i], eas[i], 32'h0000_5A5A, 16'h0, 1'b0);
            n_checks++;
            if (obs_exc !== want_exc[i] || obs_exc !== exp_exc) begin
                n_err++; $display("FAIL exc_flag%0d: got %b want %b", i, obs_exc, want_exc[i]);
            end
            if (want_exc[i]) begin
                n_checks++;
                if (obs_lat != 1 || (n_wr + n_rd) != 0 || obs_sp !== sp_before || obs_rdata !== 32'h0) begin
                    n_err++; $display("FAIL exc_side%0d: lat=%0d accesses=%0d sp=%h rdata=%h want 1 0 %h 0",
                                      i, obs_lat, n_wr + n_rd, obs_sp, obs_rdata, sp_before);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        ops = '{STD, INT, RTI};
        for (int i = 0; i < 3; i++) begin
            ref_apply(ops[i], 1'b0, 32'h20, 32'h0BAD_F00D, 16'h00C3);
            do_op(ops[i], 1'b0, 32'h20, 32'h0BAD_F00D, 16'h00C3, 1'b1);
            n_checks++;
            if (n_acc != 1 || obs_ready_busy || !obs_ready_after || obs_valid_after || obs_timeout) begin
                n_err++; $display("FAIL hold_accept%0d: accepts=%0d ready_busy=%b ready_after=%b valid_after=%b want 1 0 1 0",
                                  i, n_acc, obs_ready_busy, obs_ready_after, obs_valid_after);
            end
            n_checks++;
            if (obs_rdata !== ref_rdata || obs_sp !== ref_sp || obs_lat != exp_lat) begin
                n_err++; $display("FAIL hold_result%0d: rdata=%h sp=%h lat=%0d want %h %h %0d",
                                  i, obs_rdata, obs_sp, obs_lat, ref_rdata, ref_sp, exp_lat);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit seen_valid;
        logic [31:0] sp0;
        sp0 = ref_sp;
        n_wr = 0;
        @(negedge clk);
        i_valid = 1'b1; i_op = CALL; i_en32 = 1'b0; i_ea = 32'h0; i_wdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rmem[sp0 - 32'd1] = 16'h1357; rmem[sp0] = 16'h9BDF;
        ref_sp = SPR; ref_rdata = 32'h0; ref_flags = 16'h0;
        n_checks++;
        if (o_ready !== 1'b1 || o_sp !== SPR || o_valid !== 1'b0 || n_wr != 1) begin
            n_err++; $display("FAIL rst_midop: ready=%b sp=%h valid=%b writes=%0d want 1 %h 0 1",
                              o_ready, o_sp, o_valid, n_wr, SPR);
        end
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen_valid |= o_valid;
        end
        n_checks++;
        if (seen_valid) begin
            n_err++; $display("FAIL rst_midop_valid: got pulse want none");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            logic [2:0]  op;
            logic        en;
            logic [31:0] ea, wd;
            logic [15:0] fl;
            op = 3'($urandom);
            en = 1'($urandom);
            ea = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom_range(1, 40));
            wd = $urandom;
            fl = 16'($urandom);
            ref_apply(op, en, ea, wd, fl);
            do_op(op, en, ea, wd, fl, 1'($urandom));
            n_checks++;
            if (obs_timeout || obs_lat != exp_lat || obs_exc !== exp_exc) begin
                n_err++; $display("FAIL rnd%0d_timing op=%0d: lat=%0d exc=%b want %0d %b", i, op, obs_lat, obs_exc, exp_lat, exp_exc);
            end
            n_checks++;
            if (obs_rdata !== ref_rdata || obs_flags !== ref_flags || obs_sp !== ref_sp) begin
                n_err++; $display("FAIL rnd%0d_data op=%0d: rdata=%h flags=%h sp=%h want %h %h %h",
                                  i, op, obs_rdata, obs_flags, obs_sp, ref_rdata, ref_flags, ref_sp);
            end
            n_checks++;
            if (n_wr != exp_nwr || n_rd != exp_nrd || {obs_ready_busy, obs_ready_after, obs_valid_after} !== 3'b010) begin
                n_err++; $display("FAIL rnd%0d_ctrl op=%0d: wr=%0d rd=%0d handshake=%b%b%b want %0d %0d 010",
                                  i, op, n_wr, n_rd, obs_ready_busy, obs_ready_after, obs_valid_after, exp_nwr, exp_nrd);
            end
        end
    endtask

    task automatic test_memory_image();
        foreach (rmem[k]) begin
            n_checks++;
            if (dget(k) !== rmem[k]) begin
                n_err++; $display("FAIL mem_image[%h]: got %h want %h", k, dget(k), rmem[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_op = 3'd0; i_en32 = 1'b0;
        i_ea = 32'h0; i_wdata = 32'h0; i_flags = 16'h0;
        test_reset();
        test_ld_st();
        test_stack();
        test_int_rti();
        test_exc();
        test_back_to_back();
        test_reset_midop();
        test_random();
        test_memory_image();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
